timer_mode_controller: RTL and testbench
========================================

# timer_mode_controller

Central sequencer for the countdown timer. It turns synchronised button edge pulses and a slow tick enable into registered mode and command strobes for the counting and programming datapaths. It also drives the output-mux select. Long-press detection, pause/resume, reset, programming entry/exit and expiry alarm are all decided here.

## Interface
Parameters:
- HOLD_TICKS, 6, ticks button1 must stay held to enter programming (≥1)
- IDLE_TICKS, 60, ticks without a button edge in programming before abort; 0 disables
- TICK_W, 8, width of internal tick counters (must hold max(HOLD_TICKS, IDLE_TICKS))

Ports:
- clk  in  1  system clock; only clock in the block
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle slow-rate enable, not a clock
- bt1Rise / bt1Fall  in  1 each  button1 press/release pulses, one cycle
- bt2Rise  in  1  button2 press pulse
- programmed  in  1  programming datapath reports value accepted, one cycle
- finished  in  1  counting datapath reached zero, level or pulse
- mode  out  1  0 = counting view, 1 = programming view (mux select)
- running  out  1  counting datapath enabled
- cntReset  out  1  one-cycle pulse: reload counter to initial value
- cntLoad  out  1  one-cycle pulse: latch newly programmed initial value
- progToggle / progIncrease  out  1 each  one-cycle pulses to programming datapath
- alarm  out  1  expiry indicator

## Operation
States: STOPPED, RUNNING, HOLD, PROGRAM, EXPIRED. HOLD records its origin (STOPPED or RUNNING) in a 1-bit register.
- STOPPED/RUNNING, bt1Rise -> HOLD; clear hold counter.
- HOLD: each tick increments the hold counter, saturating.
  - bt1Fall before HOLD_TICKS ticks -> short press. Return to the opposite of origin (STOPPED↔RUNNING).
  - Counter reaches HOLD_TICKS while still held -> PROGRAM. running=0. No toggle occurs.
  - On reaching PROGRAM, the matching bt1Fall is swallowed. It is not forwarded as progToggle.
- STOPPED/RUNNING/HOLD, bt2Rise -> cntReset pulse. Go to STOPPED; HOLD is abandoned.
- RUNNING (or HOLD with origin RUNNING), finished -> EXPIRED. alarm=1, running=0.
- PROGRAM:
  - bt1Rise -> progToggle.
  - bt2Rise -> progIncrease.
  - Any edge clears the idle counter.
  - programmed -> cntLoad pulse, then STOPPED.
  - Idle counter reaches IDLE_TICKS -> STOPPED without cntLoad.
- EXPIRED: any bt1Rise or bt2Rise -> cntReset pulse, alarm=0, STOPPED.
- running=1 exactly in RUNNING, and in HOLD with origin RUNNING. mode=1 exactly in PROGRAM.

Priority for simultaneous events in one cycle: finished > bt2Rise > bt1Rise/bt1Fall > tick. Lower-priority events in that cycle are dropped, not queued. In PROGRAM: programmed > bt1Rise > bt2Rise > idle timeout.

## Timing
- All outputs registered. Each strobe is high for exactly one clk cycle, starting the cycle after the causing input.
- mode, running and alarm change in the same cycle as the state register.
- Long press enters PROGRAM on the cycle after the HOLD_TICKS-th tick seen in HOLD. Real hold time is therefore between HOLD_TICKS-1 and HOLD_TICKS tick periods.
- Reset values: state STOPPED, mode 0, running 0, alarm 0, all strobes 0, counters 0. Asserting rst_n mid-hold or mid-programming aborts immediately; no strobe is emitted.
- Counters never wrap. They saturate at all-ones of TICK_W.

## Structure
- Shared timer package holds the state encoding constants and the mode values COUNT_VIEW=0 / PROG_VIEW=1. The output mux and the programming datapath reuse these.
- One natural sub-module: tick_hold_counter. It is a resettable, saturating tick counter with a terminal-count flag, used twice (hold and idle).

## Test plan
- Reset, bt1Rise, 2 ticks, bt1Fall -> running=1. Repeat -> running=0. No progToggle either time.
- STOPPED, bt1Rise, 6 ticks held -> mode=1 one cycle after the 6th tick. Following bt1Fall -> no progToggle.
- PROGRAM, bt2Rise ×3 then bt1Rise -> three progIncrease pulses, one progToggle. Then programmed -> cntLoad once, mode=0, running=0.
- RUNNING, finished and bt2Rise in the same cycle -> EXPIRED, alarm=1, no cntReset. Next bt2Rise -> cntReset, alarm=0.
- PROGRAM with IDLE_TICKS=60, no edges for 60 ticks -> mode=0, no cntLoad. An edge at tick 59 restarts the count.
- rst_n low during HOLD after 5 ticks -> all outputs 0 at once. After release, a 1-tick press -> running=1.

Source files
------------

// File: rtl/timer_mode_controller_pkg.sv
// Shared definitions for the countdown timer: sequencer state encoding and
// the output-mux view select values reused by the mux and programming datapath.
package timer_mode_controller_pkg;

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_RUNNING = 3'd1,
        ST_HOLD    = 3'd2,
        ST_PROGRAM = 3'd3,
        ST_EXPIRED = 3'd4
    } timer_state_e;

    localparam logic COUNT_VIEW = 1'b0;
    localparam logic PROG_VIEW  = 1'b1;

    // Where a HOLD was entered from; a short press returns to the opposite.
    localparam logic ORIGIN_STOPPED = 1'b0;
    localparam logic ORIGIN_RUNNING = 1'b1;

endpackage

// File: rtl/timer_mode_controller_tick_hold_counter.sv
// Resettable saturating tick counter. o_last flags that the next counted tick
// reaches LIMIT, so the owner can act on exactly that tick. LIMIT=0 disables it.
module tick_hold_counter
    import timer_mode_controller_pkg::*;
#(
    parameter int TICK_W = 8,
    parameter int LIMIT  = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    localparam logic [TICK_W-1:0] TERM = (LIMIT > 0) ? TICK_W'(LIMIT - 1) : '0;

    logic [TICK_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last = (LIMIT > 0) && (r_cnt >= TERM);

endmodule

// File: rtl/timer_mode_controller.sv
// Countdown timer sequencer: turns button edges, tick and datapath status into
// registered mode/running/alarm levels and one-cycle command strobes.
module timer_mode_controller
    import timer_mode_controller_pkg::*;
#(
    parameter int HOLD_TICKS = 6,
    parameter int IDLE_TICKS = 60,
    parameter int TICK_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic bt1Rise,
    input  logic bt1Fall,
    input  logic bt2Rise,
    input  logic programmed,
    input  logic finished,
    output logic mode,
    output logic running,
    output logic cntReset,
    output logic cntLoad,
    output logic progToggle,
    output logic progIncrease,
    output logic alarm
);

    timer_state_e r_state, w_state_nxt;
    logic r_origin, w_origin_nxt;
    logic r_fall_pend, w_fall_pend_nxt;
    logic r_mode, r_running, r_alarm;
    logic r_cnt_reset, r_cnt_load, r_prog_toggle, r_prog_inc;
    logic w_cnt_reset_nxt, w_cnt_load_nxt, w_prog_toggle_nxt, w_prog_inc_nxt;
    logic w_hold_clr, w_hold_inc, w_hold_last;
    logic w_idle_clr, w_idle_inc, w_idle_last;
    logic w_prog_edge;

    // The release that ends a long press is not a user edge in PROGRAM.
    assign w_prog_edge = bt1Rise | bt2Rise | (bt1Fall & ~r_fall_pend);
    assign w_hold_clr  = (r_state != ST_HOLD);
    assign w_idle_clr  = (r_state != ST_PROGRAM) | w_prog_edge;

    tick_hold_counter #(
        .TICK_W (TICK_W),
        .LIMIT  (HOLD_TICKS)
    ) u_hold_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_hold_clr),
        .i_inc  (w_hold_inc),
        .o_last (w_hold_last)
    );

    tick_hold_counter #(
        .TICK_W (TICK_W),
        .LIMIT  (IDLE_TICKS)
    ) u_idle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_idle_clr),
        .i_inc  (w_idle_inc),
        .o_last (w_idle_last)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_origin_nxt      = r_origin;
        w_fall_pend_nxt   = r_fall_pend & ~bt1Fall;
        w_cnt_reset_nxt   = 1'b0;
        w_cnt_load_nxt    = 1'b0;
        w_prog_toggle_nxt = 1'b0;
        w_prog_inc_nxt    = 1'b0;
        w_hold_inc        = 1'b0;
        w_idle_inc        = 1'b0;

        unique case (r_state)
            ST_STOPPED, ST_RUNNING: begin
                if ((r_state == ST_RUNNING) && finished) begin
                    w_state_nxt = ST_EXPIRED;
                end else if (bt2Rise) begin
                    w_cnt_reset_nxt = 1'b1;
                    w_state_nxt     = ST_STOPPED;
                end else if (bt1Rise) begin
                    w_state_nxt  = ST_HOLD;
                    w_origin_nxt = (r_state == ST_RUNNING) ? ORIGIN_RUNNING : ORIGIN_STOPPED;
                end
            end
            ST_HOLD: begin
                if ((r_origin == ORIGIN_RUNNING) && finished) begin
                    w_state_nxt = ST_EXPIRED;
                end else if (bt2Rise) begin
                    w_cnt_reset_nxt = 1'b1;
                    w_state_nxt     = ST_STOPPED;
                end else if (bt1Fall) begin
                    w_state_nxt = (r_origin == ORIGIN_RUNNING) ? ST_STOPPED : ST_RUNNING;
                end else if (tick) begin
                    w_hold_inc = 1'b1;
                    if (w_hold_last) begin
                        w_state_nxt     = ST_PROGRAM;
                        w_fall_pend_nxt = 1'b1;
                    end
                end
            end
            ST_PROGRAM: begin
                if (programmed) begin
                    w_cnt_load_nxt = 1'b1;
                    w_state_nxt    = ST_STOPPED;
                end else if (bt1Rise) begin
                    w_prog_toggle_nxt = 1'b1;
                end else if (bt2Rise) begin
                    w_prog_inc_nxt = 1'b1;
                end else if (!w_prog_edge && tick) begin
                    w_idle_inc = 1'b1;
                    if (w_idle_last) begin
                        w_state_nxt = ST_STOPPED;
                    end
                end
            end
            ST_EXPIRED: begin
                if (bt1Rise || bt2Rise) begin
                    w_cnt_reset_nxt = 1'b1;
                    w_state_nxt     = ST_STOPPED;
                end
            end
            default: begin
                w_state_nxt = ST_STOPPED;
            end
        endcase
    end

    // Level outputs are decoded from the next state so they move with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_STOPPED;
            r_origin      <= ORIGIN_STOPPED;
            r_fall_pend   <= 1'b0;
            r_mode        <= COUNT_VIEW;
            r_running     <= 1'b0;
            r_alarm       <= 1'b0;
            r_cnt_reset   <= 1'b0;
            r_cnt_load    <= 1'b0;
            r_prog_toggle <= 1'b0;
            r_prog_inc    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_origin      <= w_origin_nxt;
            r_fall_pend   <= w_fall_pend_nxt;
            r_mode        <= (w_state_nxt == ST_PROGRAM) ? PROG_VIEW : COUNT_VIEW;
            r_running     <= (w_state_nxt == ST_RUNNING) ||
                             ((w_state_nxt == ST_HOLD) && (w_origin_nxt == ORIGIN_RUNNING));
            r_alarm       <= (w_state_nxt == ST_EXPIRED);
            r_cnt_reset   <= w_cnt_reset_nxt;
            r_cnt_load    <= w_cnt_load_nxt;
            r_prog_toggle <= w_prog_toggle_nxt;
            r_prog_inc    <= w_prog_inc_nxt;
        end
    end

    assign mode         = r_mode;
    assign running      = r_running;
    assign alarm        = r_alarm;
    assign cntReset     = r_cnt_reset;
    assign cntLoad      = r_cnt_load;
    assign progToggle   = r_prog_toggle;
    assign progIncrease = r_prog_inc;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Scoreboard bench for timer_mode_controller: each driven cycle queues the
// hand-derived output vector expected after the next clock edge.
module tb_timer_mode_controller;

    logic clk = 1'b0;
    logic rst_n;
    logic tick, bt1Rise, bt1Fall, bt2Rise, programmed, finished;
    logic mode, running, cntReset, cntLoad, progToggle, progIncrease, alarm;

    // Output vector: {mode, running, alarm, cntReset, cntLoad, progToggle, progIncrease}
    localparam logic [6:0] O_STOP = 7'b0000000;
    localparam logic [6:0] O_RUN  = 7'b0100000;
    localparam logic [6:0] O_EXP  = 7'b0010000;
    localparam logic [6:0] O_RST  = 7'b0001000;
    localparam logic [6:0] O_LOAD = 7'b0000100;
    localparam logic [6:0] O_PROG = 7'b1000000;
    localparam logic [6:0] O_TOG  = 7'b1000010;
    localparam logic [6:0] O_INC  = 7'b1000001;

    // Input vector: {tick, bt1Rise, bt1Fall, bt2Rise, programmed, finished}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_TICK = 6'b100000;
    localparam logic [5:0] I_B1R  = 6'b010000;
    localparam logic [5:0] I_B1F  = 6'b001000;
    localparam logic [5:0] I_B2R  = 6'b000100;
    localparam logic [5:0] I_PRG  = 6'b000010;
    localparam logic [5:0] I_FIN  = 6'b000001;

    typedef struct {
        int         due;
        logic [6:0] exp;
        string      tag;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  sb_head;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [6:0] w_obs;

    timer_mode_controller #(
        .HOLD_TICKS (6),
        .IDLE_TICKS (60),
        .TICK_W     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .bt1Rise      (bt1Rise),
        .bt1Fall      (bt1Fall),
        .bt2Rise      (bt2Rise),
        .programmed   (programmed),
        .finished     (finished),
        .mode         (mode),
        .running      (running),
        .cntReset     (cntReset),
        .cntLoad      (cntLoad),
        .progToggle   (progToggle),
        .progIncrease (progIncrease),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    assign w_obs = {mode, running, alarm, cntReset, cntLoad, progToggle, progIncrease};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (mode,run,alarm,rst,load,tog,inc) at cycle %0d",
                     tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            sb_head = sb_q.pop_front();
            check_eq(sb_head.tag, w_obs, sb_head.exp);
        end
    end

    // Called just after a rising edge; inputs are held for one full cycle.
    task automatic drive(input logic [5:0] in, input logic [6:0] exp, input string tag);
        {tick, bt1Rise, bt1Fall, bt2Rise, programmed, finished} = in;
        sb_q.push_back('{due: cyc + 1, exp: exp, tag: tag});
        @(posedge clk);
        #1;
        {tick, bt1Rise, bt1Fall, bt2Rise, programmed, finished} = I_NONE;
    endtask

    task automatic enter_program(input string tag);
        drive(I_B1R, O_STOP, tag);
        for (int i = 0; i < 5; i++) drive(I_TICK, O_STOP, tag);
        drive(I_TICK, O_PROG, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        {tick, bt1Rise, bt1Fall, bt2Rise, programmed, finished} = I_NONE;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", w_obs, O_STOP);
        rst_n = 1'b1;

        // Short presses toggle stopped/running without any programming strobe
        drive(I_B1R, O_STOP, "sp1_press");
        drive(I_TICK, O_STOP, "sp1_tick");
        drive(I_TICK, O_STOP, "sp1_tick");
        drive(I_B1F, O_RUN, "sp1_release");
        drive(I_NONE, O_RUN, "sp1_idle");
        drive(I_B1R, O_RUN, "sp2_press");
        drive(I_TICK, O_RUN, "sp2_tick");
        drive(I_TICK, O_RUN, "sp2_tick");
        drive(I_B1F, O_STOP, "sp2_release");
        drive(I_FIN, O_STOP, "stop_ignores_fin");

        // Long press: PROGRAM the cycle after the 6th tick; release swallowed
        drive(I_B1R, O_STOP, "lp_press");
        for (int i = 0; i < 5; i++) drive(I_TICK, O_STOP, "lp_tick");
        drive(I_TICK, O_PROG, "lp_enter");
        drive(I_NONE, O_PROG, "lp_hold");
        drive(I_B1F, O_PROG, "lp_release");

        // Programming strobes and load
        for (int i = 0; i < 3; i++) begin
            drive(I_B2R, O_INC, "pg_inc");
            drive(I_NONE, O_PROG, "pg_inc_gap");
        end
        drive(I_B1R, O_TOG, "pg_toggle");
        drive(I_NONE, O_PROG, "pg_toggle_gap");
        drive(I_B1R | I_B2R, O_TOG, "pg_b1_over_b2");
        drive(I_PRG, O_LOAD, "pg_load");
        drive(I_NONE, O_STOP, "pg_after_load");

        // Expiry: finished beats bt2Rise, then a button clears the alarm
        drive(I_B1R, O_STOP, "ex_press");
        drive(I_B1F, O_RUN, "ex_run");
        drive(I_FIN | I_B2R, O_EXP, "ex_fin_over_b2");
        drive(I_FIN, O_EXP, "ex_hold");
        drive(I_B2R, O_RST, "ex_clear");
        drive(I_NONE, O_STOP, "ex_after");

        // Idle timeout with the swallowed release not restarting the count
        enter_program("it1_enter");
        for (int i = 0; i < 3; i++) drive(I_TICK, O_PROG, "it1_tick");
        drive(I_B1F, O_PROG, "it1_swallow");
        for (int i = 0; i < 56; i++) drive(I_TICK, O_PROG, "it1_tick");
        drive(I_TICK, O_STOP, "it1_timeout");
        drive(I_NONE, O_STOP, "it1_after");

        // An edge at tick 59 restarts the idle count
        enter_program("it2_enter");
        drive(I_B1F, O_PROG, "it2_swallow");
        for (int i = 0; i < 59; i++) drive(I_TICK, O_PROG, "it2_tick");
        drive(I_B2R, O_INC, "it2_restart");
        for (int i = 0; i < 59; i++) drive(I_TICK, O_PROG, "it2_tick2");
        drive(I_TICK, O_STOP, "it2_timeout");

        // Asynchronous reset in a running-origin HOLD after 5 ticks
        drive(I_B1R, O_STOP, "ar_press");
        drive(I_B1F, O_RUN, "ar_run");
        drive(I_B1R, O_RUN, "ar_hold");
        for (int i = 0; i < 5; i++) drive(I_TICK, O_RUN, "ar_tick");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", w_obs, O_STOP);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(I_B1R, O_STOP, "ar2_press");
        drive(I_TICK, O_STOP, "ar2_tick");
        drive(I_B1F, O_RUN, "ar2_release");

        // Remaining priority corners
        drive(I_B1R, O_RUN, "pr_hold_run");
        drive(I_FIN | I_B1F, O_EXP, "pr_fin_over_fall");
        drive(I_B1R, O_RST, "pr_exp_b1");
        drive(I_B2R, O_RST, "pr_stop_b2");
        drive(I_B1R | I_B2R, O_RST, "pr_b2_over_b1");
        enter_program("pr_enter");
        drive(I_PRG | I_B1R, O_LOAD, "pr_load_over_b1");
        drive(I_NONE, O_STOP, "pr_final");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
